// File: rtl/sp_load_fsm.sv
// sp_load_fsm: scratchpad load sequencer, one read per matrix row,
// fanned out to NUM_CH weight/input FIFOs. Optional REQ timeout: SP_LOAD_TIMEOUT_EN.
module sp_load_fsm #(
   parameter int NUM_CH         = 4,
   parameter int ROWS           = 4,
   parameter int BITS_PER_ROW   = 128,
   parameter int WORD_W         = 32,
   parameter int ROW_STRIDE     = 16,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int CH_W          = $clog2(NUM_CH),
   localparam int ROW_W         = $clog2(ROWS),
   localparam int IW            = 2 + CH_W + WORD_W,
   localparam int DW            = BITS_PER_ROW + ROW_W
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [IW-1:0]           instr_rdata,
   input  logic                    instr_empty,
   output logic                    instr_REN,
   output logic                    sLoad,
   output logic [WORD_W-1:0]       load_addr,
   input  logic                    sLoad_hit,
   input  logic [ROW_W-1:0]        sLoad_row,
   input  logic [BITS_PER_ROW-1:0] load_data,
   input  logic [NUM_CH-1:0]       w_full,
   output logic [NUM_CH-1:0]       w_WEN,
   output logic [DW-1:0]           w_wdata,
   input  logic [NUM_CH-1:0]       r_full,
   output logic [NUM_CH-1:0]       r_WEN,
   output logic [DW-1:0]           r_wdata,
   output logic                    new_weight,
   output logic                    busy,
   output logic                    err
);

   typedef enum logic [1:0] {IDLE, REQ, PUSH, DONE} state_t;

   state_t            state_q;
   logic [1:0]        op_q;
   logic [CH_W-1:0]   ch_q;
   logic [ROW_W-1:0]  row_q;
   logic [WORD_W-1:0] addr_q;
   logic [DW-1:0]     wdata_q;
   logic              err_q;

`ifdef SP_LOAD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]  tmo_q;
`endif

   logic [1:0]        in_op;
   logic [CH_W-1:0]   in_ch;
   logic [WORD_W-1:0] in_base;
   logic              is_w;
   logic              tgt_full;
   logic              push;
   logic              last_row;
   logic [NUM_CH-1:0] ch_oh;

   assign in_op    = instr_rdata[WORD_W+CH_W +: 2];
   assign in_ch    = instr_rdata[WORD_W +: CH_W];
   assign in_base  = instr_rdata[WORD_W-1:0];

   assign is_w     = (op_q == 2'b01);
   assign tgt_full = is_w ? w_full[ch_q] : r_full[ch_q];
   assign push     = (state_q == PUSH) && !tgt_full;
   assign last_row = (row_q == ROW_W'(ROWS - 1));
   assign ch_oh    = NUM_CH'(1) << ch_q;

   // Fall-through FIFO: pop in the same cycle the entry is consumed.
   assign instr_REN  = (state_q == IDLE) && !instr_empty && !RST;
   assign sLoad      = (state_q == REQ);
   assign load_addr  = addr_q;
   assign w_WEN      = (push && is_w) ? ch_oh : '0;
   assign r_WEN      = (push && !is_w) ? ch_oh : '0;
   assign w_wdata    = wdata_q;
   assign r_wdata    = wdata_q;
   assign new_weight = (state_q == DONE) && is_w;
   assign busy       = (state_q != IDLE);
   assign err        = err_q;

   // Sequencer: instruction latch, row/address walk, sticky error.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         op_q    <= '0;
         ch_q    <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
`ifdef SP_LOAD_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!instr_empty) begin
                  op_q   <= in_op;
                  ch_q   <= in_ch;
                  addr_q <= in_base;
                  row_q  <= '0;
`ifdef SP_LOAD_TIMEOUT_EN
                  tmo_q  <= '0;
`endif
                  if (in_op == 2'b01 || in_op == 2'b10)
                     state_q <= REQ;
                  else
                     err_q <= 1'b1;
               end
            end
            REQ: begin
               if (sLoad_hit) begin
                  wdata_q <= {row_q, load_data};
                  if (sLoad_row != row_q)
                     err_q <= 1'b1;
                  state_q <= PUSH;
               end
`ifdef SP_LOAD_TIMEOUT_EN
               else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
`endif
            end
            PUSH: begin
               if (push) begin
                  if (last_row) begin
                     state_q <= DONE;
                  end else begin
                     row_q   <= row_q + ROW_W'(1);
                     addr_q  <= addr_q + WORD_W'(ROW_STRIDE);
                     state_q <= REQ;
`ifdef SP_LOAD_TIMEOUT_EN
                     tmo_q   <= '0;
`endif
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sp_load_fsm.sv
// tb_sp_load_fsm: directed and randomized loads
// checked cycle by cycle against the load protocol.
module tb_sp_load_fsm;
  localparam int NCH = 4;
  localparam int RW  = 4;
  localparam int STR = 16;
  localparam int TO  = 8;

  logic         CLK;
  logic         RST;
  logic [35:0]  instr_rdata;
  logic         instr_empty;
  logic         instr_REN;
  logic         sLoad;
  logic [31:0]  load_addr;
  logic         sLoad_hit;
  logic [1:0]   sLoad_row;
  logic [127:0] load_data;
  logic [3:0]   w_full;
  logic [3:0]   w_WEN;
  logic [129:0] w_wdata;
  logic [3:0]   r_full;
  logic [3:0]   r_WEN;
  logic [129:0] r_wdata;
  logic         new_weight;
  logic         busy;
  logic         err;

  int   total = 0;
  int   bad   = 0;
  logic err_exp = 1'b0;

  sp_load_fsm #(
    .NUM_CH(NCH), .ROWS(RW),
    .BITS_PER_ROW(128), .WORD_W(32),
    .ROW_STRIDE(STR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .instr_rdata(instr_rdata),
    .instr_empty(instr_empty),
    .instr_REN(instr_REN),
    .sLoad(sLoad), .load_addr(load_addr),
    .sLoad_hit(sLoad_hit),
    .sLoad_row(sLoad_row),
    .load_data(load_data),
    .w_full(w_full), .w_WEN(w_WEN),
    .w_wdata(w_wdata),
    .r_full(r_full), .r_WEN(r_WEN),
    .r_wdata(r_wdata),
    .new_weight(new_weight),
    .busy(busy), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [129:0] obs,
                     input logic [129:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag,
                         input logic ren,
                         input logic s,
                         input logic [3:0] ew,
                         input logic [3:0] er,
                         input logic nw,
                         input logic b);
    chk({tag, ".ren"}, instr_REN, ren);
    chk({tag, ".sLoad"}, sLoad, s);
    chk({tag, ".w_WEN"}, w_WEN, ew);
    chk({tag, ".r_WEN"}, r_WEN, er);
    chk({tag, ".nw"}, new_weight, nw);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".err"}, err, err_exp);
  endtask

  task automatic drive_full(input logic [1:0] op,
                            input int ch,
                            input logic tf);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'($urandom);
    b = 4'($urandom);
    a[ch] = tf;
    if (op == 2'b01) begin
      w_full = a;
      r_full = b;
    end else begin
      r_full = a;
      w_full = b;
    end
  endtask

  task automatic do_load(input logic [1:0] op,
                         input int ch,
                         input logic [31:0] base,
                         input int maxd,
                         input int mis_row,
                         input int hold_row,
                         input int hold_n,
                         input int rst_row);
    logic [3:0]   oh;
    logic [127:0] hd;
    logic [31:0]  ea;
    logic [1:0]   rv;
    logic         legal;
    int           dly;
    int           fn;
    oh = 4'b0001 << ch;
    hd = '0;
    legal = (op == 2'b01) || (op == 2'b10);
    instr_rdata = {op, 2'(ch), base};
    instr_empty = 1'b0;
    @(negedge CLK);
    chk_cyc("pop", 1'b1, 1'b0, 4'h0, 4'h0,
            1'b0, 1'b0);
    @(posedge CLK); #1;
    instr_empty = 1'b1;
    instr_rdata = {$urandom, 4'($urandom)};
    if (!legal) begin
      err_exp = 1'b1;
      @(negedge CLK);
      chk_cyc("illegal", 1'b0, 1'b0, 4'h0,
              4'h0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      return;
    end
    for (int r = 0; r < RW; r++) begin
      rv = 2'(r);
      ea = base + 32'(r * STR);
      dly = $urandom_range(0, maxd);
      for (int k = 0; k <= dly; k++) begin
        sLoad_hit = (k == dly);
        sLoad_row = (r == mis_row) ?
                    rv + 2'd1 : rv;
        load_data = {$urandom, $urandom,
                     $urandom, $urandom};
        drive_full(op, ch, 1'($urandom));
        @(negedge CLK);
        chk_cyc("req", 1'b0, 1'b1, 4'h0,
                4'h0, 1'b0, 1'b1);
        chk("req.addr", load_addr, ea);
        hd = load_data;
        @(posedge CLK); #1;
      end
      if (r == mis_row) err_exp = 1'b1;
      sLoad_hit = 1'($urandom);
      sLoad_row = 2'($urandom);
      load_data = {$urandom, $urandom,
                   $urandom, $urandom};
      if (r == rst_row) begin
        drive_full(op, ch, 1'b1);
        @(negedge CLK);
        chk_cyc("pre_rst", 1'b0, 1'b0, 4'h0,
                4'h0, 1'b0, 1'b1);
        RST = 1'b1;
        #1;
        err_exp = 1'b0;
        chk_cyc("rst_mid", 1'b0, 1'b0, 4'h0,
                4'h0, 1'b0, 1'b0);
        chk("rst_mid.addr", load_addr, 32'h0);
        chk("rst_mid.wdata", w_wdata, 130'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        sLoad_hit = 1'b0;
        w_full = '0;
        r_full = '0;
        return;
      end
      fn = (r == hold_row) ? hold_n :
           $urandom_range(0, 2);
      for (int k = 0; k <= fn; k++) begin
        drive_full(op, ch, k < fn);
        @(negedge CLK);
        chk_cyc("push", 1'b0, 1'b0,
                (k == fn && op == 2'b01) ?
                oh : 4'h0,
                (k == fn && op == 2'b10) ?
                oh : 4'h0,
                1'b0, 1'b1);
        chk("push.w_wdata", w_wdata, {rv, hd});
        chk("push.r_wdata", r_wdata, {rv, hd});
        @(posedge CLK); #1;
      end
    end
    sLoad_hit = 1'b0;
    w_full = '0;
    r_full = '0;
    @(negedge CLK);
    chk_cyc("done", 1'b0, 1'b0, 4'h0, 4'h0,
            op == 2'b01, 1'b1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk_cyc("idle", 1'b0, 1'b0, 4'h0, 4'h0,
            1'b0, 1'b0);
    @(posedge CLK); #1;
  endtask

  initial begin : main
    logic [1:0]  op;
    logic [31:0] base;
    int          sel;
    RST = 1'b1;
    instr_empty = 1'b0;
    instr_rdata = {2'b01, 2'd1, 32'h55};
    sLoad_hit = 1'b1;
    sLoad_row = 2'd0;
    load_data = '1;
    w_full = '0;
    r_full = '0;
    @(posedge CLK); #1;
    chk_cyc("reset", 1'b0, 1'b0, 4'h0, 4'h0,
            1'b0, 1'b0);
    chk("reset.addr", load_addr, 32'h0);
    chk("reset.w_wdata", w_wdata, 130'h0);
    chk("reset.r_wdata", r_wdata, 130'h0);
    instr_empty = 1'b1;
    sLoad_hit = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;

    do_load(2'b01, 2, 32'h100, 0,
            -1, -1, 0, -1);
    do_load(2'b10, 3, 32'h2000, 2,
            -1, 1, 5, -1);
    do_load(2'b11, 1, 32'h300, 0,
            -1, -1, 0, -1);
    do_load(2'b10, 0, 32'h400, 1,
            -1, -1, 0, -1);
    do_load(2'b01, 1, 32'h500, 1,
            1, -1, 0, -1);
    do_load(2'b01, 1, 32'h600, 1,
            -1, -1, 0, 2);
    do_load(2'b10, 2, 32'h700, 1,
            -1, -1, 0, -1);
    do_load(2'b01, 3, 32'hFFFF_FFE0, 0,
            -1, -1, 0, -1);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) op = 2'b00;
      else if (sel == 1) op = 2'b11;
      else op = sel[0] ? 2'b01 : 2'b10;
      base = (i % 6 == 0) ?
             32'hFFFF_FFC0 +
             32'($urandom_range(0, 63)) :
             $urandom;
      do_load(op, $urandom_range(0, 3), base,
              3, -1, -1, 0, -1);
    end

    instr_rdata = {2'b01, 2'd0, 32'h40};
    instr_empty = 1'b0;
    @(negedge CLK);
    chk_cyc("stall.pop", 1'b1, 1'b0, 4'h0,
            4'h0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    instr_empty = 1'b1;
    sLoad_hit = 1'b0;
`ifdef SP_LOAD_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      @(negedge CLK);
      chk_cyc("tmo.wait", 1'b0, 1'b1, 4'h0,
              4'h0, 1'b0, 1'b1);
      @(posedge CLK); #1;
    end
    err_exp = 1'b1;
    @(negedge CLK);
    chk_cyc("tmo.abort", 1'b0, 1'b0, 4'h0,
            4'h0, 1'b0, 1'b0);
`else
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      chk_cyc("stall", 1'b0, 1'b1, 4'h0,
              4'h0, 1'b0, 1'b1);
      chk("stall.addr", load_addr, 32'h40);
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    err_exp = 1'b0;
    chk_cyc("stall.rst", 1'b0, 1'b0, 4'h0,
            4'h0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
`endif
    @(posedge CLK); #1;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/sp_load_fsm.md
Name: sp_load_fsm

Overview:
- Parametrised scratchpad load sequencer for the systolic-array tensor core.
- Pops load instructions from the instruction FIFO and issues one scratchpad read per matrix row.
- Routes each returned row to the weight FIFO or the input FIFO of the channel named in the instruction.
- Generalises the fixed 4-channel weight/input fan-out to NUM_CH channels and ROWS rows, with a per-row address stride, full-FIFO back-pressure, an illegal-opcode error flag and a busy indicator.

Parameters:
NUM_CH, 4, number of weight/input FIFO channel pairs (power of 2, >=2); CH_W = $clog2(NUM_CH)
ROWS, 4, rows per matrix load (power of 2, >=2); ROW_W = $clog2(ROWS)
BITS_PER_ROW, 128, data bits per scratchpad row
WORD_W, 32, scratchpad address width
ROW_STRIDE, 16, address increment between consecutive rows
TIMEOUT_CYCLES, 64, cycles without sLoad_hit before abort (used only with SP_LOAD_TIMEOUT_EN)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
instr_rdata  in  2+CH_W+WORD_W  {opcode[1:0], channel, base_addr}; valid while instr_empty=0 (fall-through FIFO)
instr_empty  in  1  instruction FIFO empty
instr_REN  out  1  pop instruction FIFO
sLoad  out  1  scratchpad read request
load_addr  out  WORD_W  scratchpad read address
sLoad_hit  in  1  read data valid this cycle
sLoad_row  in  ROW_W  row index echoed by the scratchpad
load_data  in  BITS_PER_ROW  returned row data
w_full  in  NUM_CH  weight FIFO full, one bit per channel
w_WEN  out  NUM_CH  weight FIFO write enables, one-hot
w_wdata  out  BITS_PER_ROW+ROW_W  {row, data}, shared by all weight FIFOs
r_full  in  NUM_CH  input FIFO full, one bit per channel
r_WEN  out  NUM_CH  input FIFO write enables, one-hot
r_wdata  out  BITS_PER_ROW+ROW_W  {row, data}, shared by all input FIFOs
new_weight  out  1  1-cycle pulse when a full weight matrix has been pushed
busy  out  1  high in any state except IDLE
err  out  1  sticky error flag; cleared only by RST

Behaviour:
- Reset: state=IDLE, row=0; all outputs 0 (instr_REN, sLoad, load_addr, w_WEN, r_WEN, wdata, new_weight, busy, err). Reset mid-operation abandons the load; no partial write completes.
- Opcodes: 01 = weight load, 10 = input load, 00/11 = illegal.
- IDLE:
  - instr_empty=0 -> instr_REN=1 for that cycle; latch opcode, channel, base_addr; row=0.
  - Legal opcode -> REQ. Illegal opcode -> set err, stay IDLE (instruction is discarded).
- REQ:
  - sLoad=1, load_addr=base_addr + row*ROW_STRIDE (mod 2^WORD_W); hold both stable until sLoad_hit.
  - On sLoad_hit: capture load_data -> PUSH.
  - sLoad_hit in the same cycle sLoad first rises is legal (1-cycle hit).
  - sLoad_row != row at hit -> set err; the data is still pushed tagged with the internal row.
- PUSH:
  - Target FIFO is w[channel] for opcode 01, r[channel] for opcode 10.
  - Target full -> hold; no WEN asserted, wdata held stable.
  - Target not full -> assert exactly one WEN bit for one cycle; wdata={row, captured data}.
  - row != ROWS-1 -> row++, go to REQ. row == ROWS-1 -> DONE.
- DONE: new_weight=1 for one cycle if opcode=01; -> IDLE.
- Minimum per-row latency: 2 cycles (REQ with hit, then PUSH). A new instruction may be popped in the cycle after DONE.
- Full flags of non-target channels are ignored. sLoad_hit outside REQ is ignored.
- At most one WEN bit across w_WEN|r_WEN is high in any cycle.

Optional Feature:
SP_LOAD_TIMEOUT_EN
- Defined: a counter runs in REQ and clears on each new row request. Reaching TIMEOUT_CYCLES without sLoad_hit sets err, drops sLoad and returns to IDLE; the rest of that instruction is abandoned and new_weight is not pulsed.
- Undefined: no counter; REQ waits indefinitely.

Test Plan:
- Weight load, opcode 01, channel 2, base 0x100, immediate hits -> load_addr 0x100, 0x110, 0x120, 0x130; w_WEN=0100 four times with rows 0..3; new_weight one pulse; err=0.
- Input load, channel 3, with r_full[3]=1 for 5 cycles during row 1 -> r_WEN held 0 and wdata stable for those cycles; then 4 writes total; new_weight never pulses.
- Illegal opcode 11 followed by a valid input load -> err=1 one cycle after the first pop; second instruction completes normally; err stays 1.
- sLoad_row=2 returned while internal row=1 -> err set; data written with row tag 1.
- Assert RST during PUSH of row 2 -> all outputs 0 immediately; state IDLE; the next instruction starts at row 0.
- With SP_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, no sLoad_hit -> sLoad falls after 8 cycles; err=1; busy=0; no WEN asserted.
